mux2_rr_arbiter: RTL and testbench
==================================

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each requester data word and of out_data.
REQ-002 SHALL have parameter MAX_HOLD, default 4, legal range 1..15: maximum consecutive transfers for one requester while the other is requesting.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0 and req1, input, 1 each: requester 0 and requester 1 want the shared mux path.
REQ-006 SHALL have ports data0 and data1, input, DATA_W each: requester payloads, sampled only on a transfer.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 each: registered grants, never both high.
REQ-008 SHALL have port sel, output, 1: mux select; 1 selects requester 1, otherwise 0.
REQ-009 SHALL have port out_data, output, DATA_W: registered output word.
REQ-010 SHALL have port out_valid, output, 1: out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT0, GRANT1; gnt0=1 only in GRANT0, gnt1=1 only in GRANT1, sel=1 only in GRANT1.
REQ-013 SHALL define slot_free = !out_valid || out_ready, and transfer = (gnt0&&req0 || gnt1&&req1) && slot_free.
REQ-014 SHALL, on transfer, load out_data with the granted requester's data and set out_valid=1 on the next edge; latency is 1 cycle.
REQ-015 SHALL clear out_valid when out_ready=1 and no transfer occurs in the same cycle; simultaneous accept and transfer keeps out_valid=1 with the new word.
REQ-016 SHALL hold out_data and out_valid unchanged while out_valid=1 and out_ready=0.
REQ-017 SHALL, in IDLE with exactly one request, move to that requester's GRANT state on the next edge.
REQ-018 SHALL, in IDLE with both requests, grant the requester other than last_served; last_served is a 1-bit register, reset to 1, so requester 0 wins first.
REQ-019 SHALL keep a hold counter: cleared on every grant change and in IDLE, incremented on each transfer, saturating at MAX_HOLD.
REQ-020 SHALL, in GRANTx with reqx=0, go to GRANT of the other requester if it requests, else to IDLE.
REQ-021 SHALL, in GRANTx with the other requester requesting and the hold counter reaching MAX_HOLD (including via the current cycle's transfer), switch to the other GRANT state on the next edge.
REQ-022 SHALL remain in GRANTx while reqx=1 and the other requester is idle, regardless of the hold counter.
REQ-023 SHALL update last_served to x whenever it leaves GRANTx.
REQ-024 SHALL never transfer in the cycle of a grant change; the first transfer of a new grant is no earlier than the cycle after gnt rises.
REQ-025 SHALL keep a stalled grant (out_ready=0) without advancing the hold counter.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, set state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0, out_data=0, hold counter=0, last_served=1.
REQ-027 SHALL let rst override all activity, including mid-transfer; a pending out_data word is discarded.
REQ-028 SHALL accept requests on the first edge after rst deasserts.

Verification
REQ-029 Single requester: req0=1, data0=8'hA5, out_ready=1 -> gnt0=1 after 1 edge; out_valid=1 with out_data=8'hA5 one edge later; sel=0 throughout.
REQ-030 Contention from reset: req0=req1=1, data0=8'h11, data1=8'h22, out_ready=1, MAX_HOLD=4 -> four 8'h11 words, then sel=1 and four 8'h22 words, alternating every 4.
REQ-031 Backpressure: GRANT1 active, out_ready=0 for 5 cycles -> out_data stays frozen, out_valid=1, hold counter static, no grant change; resumes on out_ready=1.
REQ-032 Early release: GRANT0 after 2 transfers, req0 drops with req1=1 -> GRANT1 on the next edge, last_served=0, hold counter=0.
REQ-033 Reset mid-operation: rst=1 while out_valid=1 and gnt1=1 -> next edge all outputs 0, state IDLE; after release, req0=req1=1 grants requester 0 first.
REQ-034 Bench SHALL check every cycle: gnt0&&gnt1 never true, sel equals gnt1, and the out_data sequence matches a reference model of REQ-012..REQ-025.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter
// Description : Two-requester round-robin arbiter driving a shared mux path
//               into a one-word registered output slot with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;
    localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [3:0]        r_hold;
    logic [3:0]        w_hold_inc;
    logic [3:0]        w_hold_nxt;
    logic              r_gnt0;
    logic              r_gnt1;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              w_slot_free;
    logic              w_transfer;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_transfer  = ((r_gnt0 && req0) || (r_gnt1 && req1)) && w_slot_free;
    // Hold count including this cycle's transfer, so the switch decision sees it
    assign w_hold_inc  = (w_transfer && (r_hold < C_MAX_HOLD)) ? r_hold + 4'd1 : r_hold;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_hold_nxt  = w_hold_inc;
        case (r_state)
            S_IDLE: begin
                if (req0 && req1)
                    w_state_nxt = r_last ? S_GRANT0 : S_GRANT1;
                else if (req0)
                    w_state_nxt = S_GRANT0;
                else if (req1)
                    w_state_nxt = S_GRANT1;
            end
            S_GRANT0: begin
                if (!req0)
                    w_state_nxt = req1 ? S_GRANT1 : S_IDLE;
                else if (req1 && (w_hold_inc >= C_MAX_HOLD))
                    w_state_nxt = S_GRANT1;
            end
            S_GRANT1: begin
                if (!req1)
                    w_state_nxt = req0 ? S_GRANT0 : S_IDLE;
                else if (req0 && (w_hold_inc >= C_MAX_HOLD))
                    w_state_nxt = S_GRANT0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE))
            w_hold_nxt = 4'd0;
        if ((r_state == S_GRANT0) && (w_state_nxt != S_GRANT0))
            w_last_nxt = 1'b0;
        if ((r_state == S_GRANT1) && (w_state_nxt != S_GRANT1))
            w_last_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_hold      <= 4'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt0  <= (w_state_nxt == S_GRANT0);
            r_gnt1  <= (w_state_nxt == S_GRANT1);
            if (w_transfer) begin
                r_out_data  <= r_gnt1 ? data1 : data0;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign sel       = r_gnt1;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_rr_arbiter
// Description : Scoreboard bench for mux2_rr_arbiter with a tenure-based
//               reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [DATA_W-1:0] data0 = '0;
    logic [DATA_W-1:0] data1 = '0;
    logic              out_ready = 1'b0;
    logic              gnt0;
    logic              gnt1;
    logic              sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the path (-1 = nobody), transfers in this tenure,
    // who was served last, and whether the output slot is occupied.
    int                m_owner = -1;
    int                m_run   = 0;
    int                m_last  = 1;
    bit                m_valid = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] seen[$];
    bit                chk_en = 1'b0;
    bit                log_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit r0;
        bit r1;
        bit own_req;
        bit oth_req;
        bit xfer;
        r0 = req0;
        r1 = req1;
        if (rst) begin
            m_owner = -1;
            m_run   = 0;
            m_last  = 1;
            m_valid = 1'b0;
            exp_q.delete();
            return;
        end
        own_req = (m_owner == 0) ? r0 : r1;
        oth_req = (m_owner == 0) ? r1 : r0;
        xfer = (m_owner >= 0) && own_req && (!m_valid || out_ready);
        if (xfer) begin
            exp_q.push_back((m_owner == 0) ? data0 : data1);
            m_run++;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            if (r0 && r1)  m_owner = 1 - m_last;
            else if (r0)   m_owner = 0;
            else if (r1)   m_owner = 1;
            m_run = 0;
        end else if (!own_req || (oth_req && m_run >= MAX_HOLD)) begin
            m_last  = m_owner;
            m_owner = oth_req ? 1 - m_owner : -1;
            m_run   = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt_exclusive", 32'(gnt0 && gnt1), 32'd0);
            check("sel_eq_gnt1", 32'(sel), 32'(gnt1));
            check("gnt0", 32'(gnt0), 32'(m_owner == 0));
            check("gnt1", 32'(gnt1), 32'(m_owner == 1));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_data: got %0h expected none (scoreboard empty) at %0t", out_data, $time);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                if (log_en) seen.push_back(out_data);
            end
        end
    end

    initial begin
        bit found;
        logic [DATA_W-1:0] want;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_data", 32'(out_data), 32'd0);

        // Single requester
        req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
        repeat (4) step();
        req0 = 1'b0;
        repeat (3) step();

        // Contention from reset: expect 4 x 11 then 4 x 22
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; out_ready = 1'b1;
        seen.delete();
        log_en = 1'b1;
        repeat (20) step();
        log_en = 1'b0;
        check("contention_count_ok", 32'(seen.size() >= 16), 32'd1);
        for (int i = 0; i < 16 && i < seen.size(); i++) begin
            want = ((i / MAX_HOLD) % 2 == 0) ? 8'h11 : 8'h22;
            check("contention_seq", 32'(seen[i]), 32'(want));
        end

        // Backpressure during GRANT1
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (m_owner == 1) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_grant1: got no grant1 expected grant1 within 30 cycles");
        end
        step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (6) step();

        // Early release after 2 transfers
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1;
        repeat (3) step();
        req0 = 1'b0; req1 = 1'b1;
        repeat (4) step();
        req1 = 1'b0;
        repeat (2) step();

        // Reset mid-operation with a pending word
        req1 = 1'b1; out_ready = 1'b0; data1 = 8'h5C;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 100) == 0;
            req0      = ($urandom % 4) != 0;
            req1      = ($urandom % 4) != 0;
            data0     = DATA_W'($urandom);
            data1     = DATA_W'($urandom);
            out_ready = ($urandom % 4) != 0;
            step();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
